// File: rtl/rice_decode_ctrl_if.sv
// rice_decode_ctrl_if: bitstream-in / symbol-out handshake bundle for the Rice decode controller
interface rice_decode_ctrl_if #(
    parameter int W_WORD = 32,
    parameter int W_OUT  = 20
);
    logic [W_WORD-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [W_OUT-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              err;
    modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid, err);
    modport slave  (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid, err);
endinterface

// File: rtl/rice_decode_ctrl.sv
// rice_decode_ctrl: buffers an MSB-first word stream and decodes Rice symbols {quotient, remainder}
module count_lead_zero #(
    parameter int W_IN = 32
) (
    input  logic [W_IN-1:0]      data,
    output logic [$clog2(W_IN):0] count
);
    localparam int CW = $clog2(W_IN) + 1;
    always_comb begin
        count = CW'(W_IN);
        for (int i = 0; i < W_IN; i++)
            if (data[i]) count = CW'(W_IN - 1 - i);
    end
endmodule

module rice_decode_ctrl #(
    parameter int W_WORD = 32,
    parameter int K      = 4,
    parameter int W_Q    = 16
) (
    input logic               clk,
    input logic               rst,
    rice_decode_ctrl_if.slave bus
);
    localparam int NW    = $clog2(2 * W_WORD) + 1;
    localparam int CW    = $clog2(W_WORD) + 1;
    localparam int W_OUT = W_Q + K;

    typedef enum logic [1:0] {PREFIX, REM, OUT} state_t;

    state_t              state, state_next;
    logic [2*W_WORD-1:0] buf_q, buf_next;
    logic [NW-1:0]       n, n_next, shift;
    logic [W_Q-1:0]      q, q_next;
    logic [W_Q:0]        q_sum;
    logic [W_OUT-1:0]    out_data_next;
    logic                err_next;
    logic [CW-1:0]       z;
    logic                accept;

    count_lead_zero #(.W_IN(W_WORD)) u_clz (.data(buf_q[2*W_WORD-1 -: W_WORD]), .count(z));

    assign bus.in_ready  = n <= NW'(W_WORD);
    assign bus.out_valid = state == OUT;
    assign accept        = bus.in_valid && bus.in_ready;
    assign q_sum         = {1'b0, q} + (W_Q + 1)'(z);

    always_comb begin
        state_next    = state;
        shift         = '0;
        q_next        = q;
        err_next      = bus.err;
        out_data_next = bus.out_data;
        case (state)
            PREFIX: if (n >= NW'(W_WORD)) begin
                // an all-zero window consumes the whole word; otherwise drop the terminator too
                shift      = (z == CW'(W_WORD)) ? NW'(W_WORD) : NW'(z + CW'(1));
                q_next     = q_sum[W_Q] ? '1 : q_sum[W_Q-1:0];
                err_next   = bus.err | q_sum[W_Q];
                state_next = (z == CW'(W_WORD)) ? PREFIX : REM;
            end
            REM: if (n >= NW'(K)) begin
                shift         = NW'(K);
                out_data_next = {q, buf_q[2*W_WORD-1 -: K]};
                state_next    = OUT;
            end
            OUT: if (bus.out_ready) begin
                q_next     = '0;
                state_next = PREFIX;
            end
            default: state_next = PREFIX;
        endcase
        // append lands at the post-shift fill level
        buf_next = (buf_q << shift) | (accept ? ({bus.in_data, {W_WORD{1'b0}}} >> (n - shift)) : '0);
        n_next   = n - shift + (accept ? NW'(W_WORD) : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= PREFIX;
            buf_q        <= '0;
            n            <= '0;
            q            <= '0;
            bus.out_data <= '0;
            bus.err      <= 1'b0;
        end else begin
            state        <= state_next;
            buf_q        <= buf_next;
            n            <= n_next;
            q            <= q_next;
            bus.out_data <= out_data_next;
            bus.err      <= err_next;
        end
    end
endmodule

// File: doc/rice_decode_ctrl.md
Name: rice_decode_ctrl

Overview:
- Sequencing controller for the Rice/unary decoder path.
- Buffers an MSB-first bitstream of W_WORD-bit words and drives a count_lead_zero instance (W_IN=W_WORD) on the buffer head to measure unary prefixes, including prefixes that span words.
- Extracts the K-bit remainder and emits one decoded symbol per valid/ready transaction.
- Sits between the bitstream fetch unit and downstream symbol consumers.

Parameters:
W_WORD, 32, input word width; power of two ≥ 8; also the CLZ window width
K, 4, fixed Rice remainder width in bits, 1..W_WORD-1
W_Q, 16, quotient width; W_OUT = W_Q+K

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_data  in  W_WORD  stream word; bit W_WORD-1 is decoded first
in_valid  in  1  in_data valid
in_ready  out  1  controller accepts word this cycle
out_data  out  W_Q+K  decoded symbol {quotient, remainder}
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts symbol
err  out  1  sticky quotient-overflow flag

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset state: buf=0, n=0, q=0, state=PREFIX, out_valid=0, out_data=0, err=0. in_ready is combinational and is 1 after reset.
- Buffer: 2*W_WORD-bit register `buf`, left-aligned. Valid-bit count `n` ranges 0..2*W_WORD.
- in_ready = (n ≤ W_WORD). A word is accepted on in_valid & in_ready.
- On accept, the word is written at buf bit offset n from the MSB, after any same-cycle shift. In that cycle, n_next = n − shift + W_WORD.
- Unary code: q zeros, then a terminating 1, then K remainder bits (MSB first).
- FSM states: PREFIX, REM, OUT.
- PREFIX, n ≥ W_WORD: z = CLZ(buf[top W_WORD]).
  - z == W_WORD: q += W_WORD; shift out W_WORD bits; stay in PREFIX.
  - z < W_WORD: q += z; shift out z+1 bits (terminator dropped); go to REM.
- PREFIX, n < W_WORD: stall. No partial-window evaluation.
- REM, n ≥ K: r = top K bits; shift out K bits; latch out_data = {q_sat, r}; out_valid=1; go to OUT.
- REM, n < K: stall.
- OUT: hold out_data stable while out_valid & !out_ready. On out_ready: out_valid=0, q=0, go to PREFIX.
- Input acceptance continues in every state, subject to in_ready.
- Throughput: minimum 3 cycles per symbol (PREFIX→REM→OUT handshake), plus one extra PREFIX cycle per all-zero window.
- Quotient arithmetic: internal accumulator is W_Q+1 bits. If q would exceed 2^W_Q−1, it saturates at 2^W_Q−1 and err is set. err stays set until rst. Decoding continues with the saturated value.
- Boundary conditions:
  - n == W_WORD exactly: in_ready=1, and PREFIX may evaluate in the same cycle.
  - Shift and append in the same cycle: shift first, then append at the post-shift offset.
  - Prefix ending at the last bit of the window (z = W_WORD−1): remainder bits come from the following word; REM stalls until n ≥ K.
- Reset mid-operation: rst overrides everything in its cycle. The partial symbol and buffered bits are discarded, and out_valid drops the next cycle.

Test Plan:
- q=3 across a single word: rst, then words 0x1A000000 and 0x00000000 → out_data=0x03A (q=3, r=0xA), out_valid within 4 cycles of first accept, err=0.
- q=0: word 0xF0000000 → out_data=0x00E. Then the stream continues with the remaining 27 zeros plus the next word 0x80000000 → second symbol q=27, r=0 → 0x1B0.
- Prefix spanning words: words 0x00000000, 0x80000000 → one extra PREFIX cycle, out_data=0x200 (q=32, r=0).
- Backpressure: out_ready held low 10 cycles during OUT with in_valid=1 throughout:
  - out_data stays constant;
  - in_ready=0 once n > 32;
  - no word is lost; symbols after release match the golden model.
- Overflow: 2049 consecutive 0x00000000 words, then 0x80000000 → out_data=0xFFFF0 (q saturated to 0xFFFF, r=0), err=1 and remains 1 across later symbols.
- Reset mid-symbol: assert rst for 1 cycle while in PREFIX with q=32 accumulated → next cycle n=0, out_valid=0, err=0. Then word 0x1A000000 followed by a zero word decodes to 0x03A.
